stump_timer: RTL and testbench
==============================

# stump_timer

Memory-mapped 16-bit down-counting timer on the Stump memory bus. Sits directly downstream of the Stump core: it decodes the core's `address`, `data_out`, `mem_wen` and `mem_ren`, and drives read data back onto the core's `data_in` path. The system OR-combines that read data with RAM read data. It supports one-shot and auto-reload modes, a sticky expiry flag and a level interrupt output.

## Interface
- `BASE`, 16'hFFF0, base word address; must be 8-word aligned (bits [2:0] = 0).
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `address`  input  16  word address from the core.
- `wr_data`  input  16  write data (the core's `data_out`).
- `mem_wen`  input  1  write strobe, sampled on the rising edge.
- `mem_ren`  input  1  read strobe.
- `rd_data`  output  16  read data; 16'h0000 when not selected.
- `sel`  output  1  high when `address[15:3] == BASE[15:3]`.
- `irq`  output  1  interrupt request, level.

## Operation
- Register map (offset = `address[2:0]`):
  - 0 CTRL: [0] EN, [1] AUTO, [2] IRQ_EN; other bits read 0.
  - 1 LOAD: reload value.
  - 2 COUNT: current count, read/write.
  - 3 STATUS: [0] EXPIRED (write 1 to clear), [1] RUNNING (read-only, equals EN).
  - 4 PRESC: see Configuration.
  - 5–7: read 0; writes ignored.
- `rd_data`:
  - Combinational: selected register when `sel & mem_ren`, else 0.
  - If `mem_wen` and `mem_ren` are both high, the read returns the pre-write value.
- FSM has two states, IDLE (EN=0) and RUN (EN=1).
- IDLE→RUN on a CTRL write with EN=1; on that edge COUNT<=LOAD.
- CTRL write with EN=1 while already in RUN: COUNT is not reloaded; AUTO and IRQ_EN update.
- RUN→IDLE on a CTRL write with EN=0, or on a one-shot expiry.
- In RUN, on each tick:
  - COUNT≠0: COUNT<=COUNT−1.
  - COUNT==0: EXPIRED<=1. If AUTO, COUNT<=LOAD; else EN<=0 and COUNT holds at 0.
- Period: LOAD=N gives expiry every N+1 ticks. LOAD=0 in AUTO mode expires every tick.
- COUNT does not wrap below 0.
- `irq` = EXPIRED & IRQ_EN, driven from registers (glitch-free).
- Simultaneous events:
  - CPU write to COUNT in the same cycle as a tick: the write wins, and no expiry is evaluated that cycle.
  - STATUS clear in the same cycle as an expiry: EXPIRED stays 1 (set wins).
  - CTRL write EN=0 in the same cycle as an expiry: EXPIRED sets and EN clears.
  - LOAD write in the same cycle as an auto-reload: COUNT takes the old LOAD; the new LOAD applies from the next reload.
- Reset (asserted at any time, including mid-count):
  - All registers are 0 and the FSM is in IDLE.
  - `irq`=0, `rd_data`=0, `sel` follows `address`.
  - Operation resumes on the first rising edge after deassertion.

## Timing
- Write latency: a register written at edge k reads back the new value in the cycle after k.
- Read latency: zero cycles (combinational).
- Start sequence (no prescale), CTRL EN=1 written at edge k, LOAD=3:
  - COUNT=3 after edge k.
  - COUNT = 2, 1, 0 after edges k+1, k+2, k+3.
  - EXPIRED=1 after edge k+4.
  - `irq` high in the same cycle as EXPIRED if IRQ_EN=1.
- EXPIRED clears on the edge of the STATUS write with bit0=1; `irq` falls in the same cycle as EXPIRED.

## Configuration
- Macro: `STUMP_TIMER_PRESCALE_EN`.
- Defined:
  - 16-bit PRESC register at offset 4, plus an internal prescale counter.
  - A tick occurs when the prescale counter == PRESC; the counter then returns to 0, otherwise it increments.
  - The prescale counter is 0 in IDLE and is zeroed on IDLE→RUN.
  - PRESC=0 gives a tick every cycle. PRESC=P gives a tick every P+1 cycles.
- Undefined:
  - No PRESC register; offset 4 reads 0 and writes are ignored.
  - Tick = every cycle in RUN.

## Test plan
- Reset mid-count (LOAD=100, running, `rst` low) → COUNT=0, EN=0, `irq`=0, `rd_data`=0 immediately; COUNT still 0 five cycles after release.
- One-shot: LOAD=3, CTRL=16'h0005 at edge k → COUNT reads 3,2,1,0; EXPIRED=1 and `irq`=1 after edge k+4; STATUS reads 16'h0001; COUNT stays 0.
- Auto-reload: LOAD=2, CTRL=16'h0003 → EXPIRED sets after edge k+3; COUNT reads 2 after that edge; write STATUS=16'h0001 → EXPIRED=0; re-sets 3 cycles later.
- Collisions:
  - STATUS clear in the expiry cycle → EXPIRED remains 1.
  - COUNT write of 16'h0010 in a tick cycle → COUNT reads 16'h0010.
- Decode with BASE=16'hFFF0: read at 16'hFFE8 → `sel`=0, `rd_data`=0; read at 16'hFFF6 → 0; write at 16'hFFF7 → no register changes.
- With `STUMP_TIMER_PRESCALE_EN`: PRESC=3, LOAD=1, AUTO → expiry every 8 cycles. Without the macro: offset 4 reads 0 after writing 16'h0003.

Source files
------------

// File: rtl/stump_timer.sv
`default_nettype none
// ============================================================================
// stump_timer : memory-mapped 16-bit down-counting timer on the Stump bus.
// Optional prescaler is compiled in when STUMP_TIMER_PRESCALE_EN is defined.
// Revision: 1.0
// ============================================================================
module stump_timer #(
    parameter logic [15:0] BASE = 16'hFFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] wr_data,
    input  logic        mem_wen,
    input  logic        mem_ren,
    output logic [15:0] rd_data,
    output logic        sel,
    output logic        irq
);
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_LOAD   = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_PRESC  = 3'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_next;
    logic        auto_mode, auto_next;
    logic        irq_en, irq_en_next;
    logic        expired, expired_next;
    logic [15:0] load_val, count, count_next;
    logic [2:0]  offset;
    logic        wr_ctrl, wr_load, wr_count, wr_status;
    logic        tick, expire;
    logic [15:0] presc_rd;

    assign sel       = (address[15:3] == BASE[15:3]);
    assign offset    = address[2:0];
    assign wr_ctrl   = sel && mem_wen && (offset == OFF_CTRL);
    assign wr_load   = sel && mem_wen && (offset == OFF_LOAD);
    assign wr_count  = sel && mem_wen && (offset == OFF_COUNT);
    assign wr_status = sel && mem_wen && (offset == OFF_STATUS);

`ifdef STUMP_TIMER_PRESCALE_EN
    logic [15:0] presc, pre_cnt;
    logic        wr_presc;

    assign wr_presc = sel && mem_wen && (offset == OFF_PRESC);
    assign tick     = (state == RUN) && (pre_cnt == presc);
    assign presc_rd = presc;

    // Prescale counter only advances while the timer stays running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc   <= '0;
            pre_cnt <= '0;
        end else begin
            if (wr_presc) begin
                presc <= wr_data;
            end
            if ((state == RUN) && (state_next == RUN)) begin
                pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            end else begin
                pre_cnt <= '0;
            end
        end
    end
`else
    assign tick     = (state == RUN);
    assign presc_rd = '0;
`endif

    // A CPU write to COUNT overrides the tick, so no expiry is evaluated.
    assign expire = tick && (count == 16'd0) && !wr_count;

    always_comb begin
        state_next   = state;
        count_next   = count;
        auto_next    = auto_mode;
        irq_en_next  = irq_en;
        expired_next = expired;

        if (wr_ctrl) begin
            auto_next   = wr_data[1];
            irq_en_next = wr_data[2];
        end
        if (wr_status && wr_data[0]) begin
            expired_next = 1'b0;
        end
        if (expire) begin
            expired_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (wr_ctrl && wr_data[0]) begin
                    state_next = RUN;
                    count_next = load_val;
                end
            end
            RUN: begin
                if (expire) begin
                    if (auto_mode) begin
                        count_next = load_val;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (tick && (count != 16'd0)) begin
                    count_next = count - 16'd1;
                end
                if (wr_ctrl) begin
                    state_next = wr_data[0] ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (wr_count) begin
            count_next = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            load_val  <= '0;
            auto_mode <= 1'b0;
            irq_en    <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            auto_mode <= auto_next;
            irq_en    <= irq_en_next;
            expired   <= expired_next;
            if (wr_load) begin
                load_val <= wr_data;
            end
        end
    end

    assign irq = expired && irq_en;

    always_comb begin
        rd_data = '0;
        if (sel && mem_ren) begin
            case (offset)
                OFF_CTRL:   rd_data = {13'd0, irq_en, auto_mode, state == RUN};
                OFF_LOAD:   rd_data = load_val;
                OFF_COUNT:  rd_data = count;
                OFF_STATUS: rd_data = {14'd0, state == RUN, expired};
                OFF_PRESC:  rd_data = presc_rd;
                default:    rd_data = '0;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_stump_timer.sv
`default_nettype none
// ============================================================================
// tb_stump_timer : self-checking bench for stump_timer (randomized LOAD values,
// expected counts derived arithmetically from the programmed period).
// Revision: 1.0
// ============================================================================
module tb_stump_timer;
    localparam logic [15:0] BASE     = 16'hFFF0;
    localparam logic [15:0] A_CTRL   = 16'hFFF0;
    localparam logic [15:0] A_LOAD   = 16'hFFF1;
    localparam logic [15:0] A_COUNT  = 16'hFFF2;
    localparam logic [15:0] A_STATUS = 16'hFFF3;
    localparam logic [15:0] A_PRESC  = 16'hFFF4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] wr_data = '0;
    logic        mem_wen = 1'b0;
    logic        mem_ren = 1'b0;
    logic [15:0] rd_data;
    logic        sel;
    logic        irq;

    int tests_run = 0;
    int failed    = 0;

    stump_timer #(.BASE(BASE)) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .wr_data (wr_data),
        .mem_wen (mem_wen),
        .mem_ren (mem_ren),
        .rd_data (rd_data),
        .sel     (sel),
        .irq     (irq)
    );

    always #10 clk = ~clk;

    // Called in the low clock phase; the write lands on the next rising edge.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        address = a;
        wr_data = d;
        mem_wen = 1'b1;
        @(negedge clk);
        mem_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        address = a;
        mem_ren = 1'b1;
        #1;
        d = rd_data;
        mem_ren = 1'b0;
    endtask

    task automatic quiesce();
        bus_write(A_CTRL, 16'h0000);
        bus_write(A_STATUS, 16'h0001);
        bus_write(A_COUNT, 16'h0000);
        bus_write(A_LOAD, 16'h0000);
        bus_write(A_PRESC, 16'h0000);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin failed++; $display("FAIL reset_irq_during: got %b expected 0", irq); end
        rst = 1'b1;
        @(negedge clk);
        for (int off = 0; off < 8; off++) begin
            bus_read(BASE + 16'(off), v);
            tests_run++;
            if (v !== 16'h0000) begin failed++; $display("FAIL reset_reg%0d: got %h expected 0000", off, v); end
        end
        tests_run++;
        if (irq !== 1'b0 || rd_data !== 16'h0000) begin
            failed++; $display("FAIL reset_outputs: got irq=%b rd=%h expected irq=0 rd=0000", irq, rd_data);
        end
    endtask

    task automatic test_one_shot(input int n);
        logic [15:0] v;
        quiesce();
        bus_write(A_LOAD, 16'(n));
        bus_write(A_CTRL, 16'h0005);
        for (int j = 0; j <= n; j++) begin
            if (j > 0) @(negedge clk);
            bus_read(A_COUNT, v);
            tests_run++;
            if (v !== 16'(n - j)) begin failed++; $display("FAIL oneshot_count n=%0d j=%0d: got %h expected %h", n, j, v, 16'(n - j)); end
            bus_read(A_STATUS, v);
            tests_run++;
            if (v !== 16'h0002 || irq !== 1'b0) begin
                failed++; $display("FAIL oneshot_status_run n=%0d j=%0d: got %h irq=%b expected 0002 irq=0", n, j, v, irq);
            end
        end
        @(negedge clk);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0001 || irq !== 1'b1) begin
            failed++; $display("FAIL oneshot_expired n=%0d: got %h irq=%b expected 0001 irq=1", n, v, irq);
        end
        bus_read(A_CTRL, v);
        tests_run++;
        if (v !== 16'h0004) begin failed++; $display("FAIL oneshot_ctrl n=%0d: got %h expected 0004", n, v); end
        repeat (3) @(negedge clk);
        bus_read(A_COUNT, v);
        tests_run++;
        if (v !== 16'h0000) begin failed++; $display("FAIL oneshot_hold n=%0d: got %h expected 0000", n, v); end
        bus_write(A_STATUS, 16'h0001);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0000 || irq !== 1'b0) begin
            failed++; $display("FAIL oneshot_clear n=%0d: got %h irq=%b expected 0000 irq=0", n, v, irq);
        end
    endtask

    task automatic test_auto(input int n);
        logic [15:0] v;
        logic [15:0] exp_status;
        quiesce();
        bus_write(A_LOAD, 16'(n));
        bus_write(A_CTRL, 16'h0003);
        for (int j = 0; j <= 3 * (n + 1); j++) begin
            if (j > 0) @(negedge clk);
            bus_read(A_COUNT, v);
            tests_run++;
            if (v !== 16'(n - (j % (n + 1)))) begin
                failed++; $display("FAIL auto_count n=%0d j=%0d: got %h expected %h", n, j, v, 16'(n - (j % (n + 1))));
            end
            exp_status = (j >= n + 1) ? 16'h0003 : 16'h0002;
            bus_read(A_STATUS, v);
            tests_run++;
            if (v !== exp_status || irq !== 1'b0) begin
                failed++; $display("FAIL auto_status n=%0d j=%0d: got %h irq=%b expected %h irq=0", n, j, v, irq, exp_status);
            end
        end
    endtask

    task automatic test_auto_clear();
        logic [15:0] v;
        quiesce();
        bus_write(A_LOAD, 16'd2);
        bus_write(A_CTRL, 16'h0003);
        repeat (3) @(negedge clk);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0003) begin failed++; $display("FAIL autoclr_set: got %h expected 0003", v); end
        bus_read(A_COUNT, v);
        tests_run++;
        if (v !== 16'h0002) begin failed++; $display("FAIL autoclr_reload: got %h expected 0002", v); end
        bus_write(A_STATUS, 16'h0001);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0002) begin failed++; $display("FAIL autoclr_cleared: got %h expected 0002", v); end
        @(negedge clk);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0002) begin failed++; $display("FAIL autoclr_early: got %h expected 0002", v); end
        @(negedge clk);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0003) begin failed++; $display("FAIL autoclr_reset: got %h expected 0003", v); end
    endtask

    task automatic test_collisions();
        logic [15:0] v;
        logic [15:0] cv;
        // STATUS clear on the expiry edge: set wins.
        quiesce();
        bus_write(A_LOAD, 16'd1);
        bus_write(A_CTRL, 16'h0005);
        @(negedge clk);
        bus_write(A_STATUS, 16'h0001);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0001 || irq !== 1'b1) begin
            failed++; $display("FAIL coll_status_clear: got %h irq=%b expected 0001 irq=1", v, irq);
        end
        // COUNT write on a tick edge: write wins.
        for (int r = 0; r < 3; r++) begin
            quiesce();
            cv = (r == 0) ? 16'h0010 : 16'($urandom_range(1, 16'hFFFF));
            bus_write(A_LOAD, 16'h0040);
            bus_write(A_CTRL, 16'h0003);
            repeat (2) @(negedge clk);
            bus_write(A_COUNT, cv);
            bus_read(A_COUNT, v);
            tests_run++;
            if (v !== cv) begin failed++; $display("FAIL coll_count_write: got %h expected %h", v, cv); end
            @(negedge clk);
            bus_read(A_COUNT, v);
            tests_run++;
            if (v !== cv - 16'd1) begin failed++; $display("FAIL coll_count_next: got %h expected %h", v, cv - 16'd1); end
        end
        // CTRL EN=0 on the expiry edge: EXPIRED sets, EN clears.
        quiesce();
        bus_write(A_LOAD, 16'd1);
        bus_write(A_CTRL, 16'h0003);
        @(negedge clk);
        bus_write(A_CTRL, 16'h0000);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0001) begin failed++; $display("FAIL coll_stop_expire: got %h expected 0001", v); end
        // LOAD write on an auto-reload edge: old LOAD used, new one next time.
        quiesce();
        bus_write(A_LOAD, 16'd2);
        bus_write(A_CTRL, 16'h0003);
        repeat (2) @(negedge clk);
        bus_write(A_LOAD, 16'd5);
        bus_read(A_COUNT, v);
        tests_run++;
        if (v !== 16'd2) begin failed++; $display("FAIL coll_load_old: got %h expected 0002", v); end
        repeat (3) @(negedge clk);
        bus_read(A_COUNT, v);
        tests_run++;
        if (v !== 16'd5) begin failed++; $display("FAIL coll_load_new: got %h expected 0005", v); end
    endtask

    task automatic test_decode();
        logic [15:0] v;
        quiesce();
        bus_write(A_LOAD, 16'h1234);
        bus_write(A_COUNT, 16'h0055);
        bus_write(A_CTRL, 16'h0006);
        bus_read(16'hFFE8, v);
        tests_run++;
        if (v !== 16'h0000 || sel !== 1'b0) begin failed++; $display("FAIL decode_outside: got rd=%h sel=%b expected 0000 sel=0", v, sel); end
        bus_read(16'hFFF6, v);
        tests_run++;
        if (v !== 16'h0000 || sel !== 1'b1) begin failed++; $display("FAIL decode_off6: got rd=%h sel=%b expected 0000 sel=1", v, sel); end
        address = A_LOAD;
        #1;
        tests_run++;
        if (rd_data !== 16'h0000) begin failed++; $display("FAIL decode_noren: got %h expected 0000", rd_data); end
        bus_write(16'hFFF5, 16'hFFFF);
        bus_write(16'hFFF6, 16'hFFFF);
        bus_write(16'hFFF7, 16'hFFFF);
        bus_write(16'hFFE9, 16'hBEEF);
        bus_write(16'hFFEA, 16'hBEEF);
        bus_write(16'hFFE8, 16'h0001);
        repeat (2) @(negedge clk);
        bus_read(A_CTRL, v);
        tests_run++;
        if (v !== 16'h0006) begin failed++; $display("FAIL decode_ctrl: got %h expected 0006", v); end
        bus_read(A_LOAD, v);
        tests_run++;
        if (v !== 16'h1234) begin failed++; $display("FAIL decode_load: got %h expected 1234", v); end
        bus_read(A_COUNT, v);
        tests_run++;
        if (v !== 16'h0055) begin failed++; $display("FAIL decode_count: got %h expected 0055", v); end
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0000) begin failed++; $display("FAIL decode_status: got %h expected 0000", v); end
        // Simultaneous read and write returns the pre-write value.
        address = A_LOAD;
        wr_data = 16'hA5A5;
        mem_wen = 1'b1;
        mem_ren = 1'b1;
        #1;
        tests_run++;
        if (rd_data !== 16'h1234) begin failed++; $display("FAIL rdwr_prewrite: got %h expected 1234", rd_data); end
        @(negedge clk);
        mem_wen = 1'b0;
        #1;
        tests_run++;
        if (rd_data !== 16'hA5A5) begin failed++; $display("FAIL rdwr_postwrite: got %h expected a5a5", rd_data); end
        mem_ren = 1'b0;
    endtask

    task automatic test_prescale();
        logic [15:0] v;
        logic [15:0] exp_status;
        int          t;
        quiesce();
        bus_write(A_PRESC, 16'h0003);
`ifdef STUMP_TIMER_PRESCALE_EN
        bus_read(A_PRESC, v);
        tests_run++;
        if (v !== 16'h0003) begin failed++; $display("FAIL presc_reg: got %h expected 0003", v); end
        bus_write(A_LOAD, 16'd1);
        bus_write(A_CTRL, 16'h0003);
        // Ticks land every 4th edge; LOAD=1 expires on every 2nd tick.
        for (int j = 0; j <= 20; j++) begin
            if (j > 0) @(negedge clk);
            t = j / 4;
            bus_read(A_COUNT, v);
            tests_run++;
            if (v !== 16'(1 - (t % 2))) begin failed++; $display("FAIL presc_count j=%0d: got %h expected %h", j, v, 16'(1 - (t % 2))); end
            exp_status = (t >= 2) ? 16'h0003 : 16'h0002;
            bus_read(A_STATUS, v);
            tests_run++;
            if (v !== exp_status) begin failed++; $display("FAIL presc_status j=%0d: got %h expected %h", j, v, exp_status); end
        end
        bus_write(A_STATUS, 16'h0001);
        repeat (2) @(negedge clk);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0002) begin failed++; $display("FAIL presc_cleared: got %h expected 0002", v); end
        @(negedge clk);
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0003) begin failed++; $display("FAIL presc_period8: got %h expected 0003", v); end
`else
        bus_read(A_PRESC, v);
        tests_run++;
        if (v !== 16'h0000) begin failed++; $display("FAIL presc_absent: got %h expected 0000", v); end
        t = 0;
`endif
    endtask

    task automatic test_reset_mid_count();
        logic [15:0] v;
        quiesce();
        bus_write(A_LOAD, 16'd100);
        bus_write(A_CTRL, 16'h0007);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (irq !== 1'b0 || rd_data !== 16'h0000) begin
            failed++; $display("FAIL rstmid_outputs: got irq=%b rd=%h expected irq=0 rd=0000", irq, rd_data);
        end
        bus_read(A_COUNT, v);
        tests_run++;
        if (v !== 16'h0000) begin failed++; $display("FAIL rstmid_count: got %h expected 0000", v); end
        bus_read(A_CTRL, v);
        tests_run++;
        if (v !== 16'h0000) begin failed++; $display("FAIL rstmid_ctrl: got %h expected 0000", v); end
        tests_run++;
        if (sel !== 1'b1) begin failed++; $display("FAIL rstmid_sel: got %b expected 1", sel); end
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(A_COUNT, v);
        tests_run++;
        if (v !== 16'h0000) begin failed++; $display("FAIL rstmid_after: got %h expected 0000", v); end
        bus_read(A_STATUS, v);
        tests_run++;
        if (v !== 16'h0000) begin failed++; $display("FAIL rstmid_status: got %h expected 0000", v); end
    endtask

    initial begin
        test_reset();
        test_one_shot(3);
        test_one_shot(int'($urandom_range(1, 12)));
        test_one_shot(int'($urandom_range(1, 12)));
        test_auto(0);
        test_auto(int'($urandom_range(1, 6)));
        test_auto(int'($urandom_range(1, 6)));
        test_auto_clear();
        test_collisions();
        test_decode();
        test_prescale();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
